// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared FSM encoding and timing defaults for the SPI DMA controller
package spi_pkg;

   localparam int XFER_WAIT_DEF = 17;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FETCH = 3'd1,
      ST_SEND  = 3'd2,
      ST_WAIT  = 3'd3,
      ST_STORE = 3'd4,
      ST_FIN   = 3'd5
   } state_t;

   function automatic logic [7:0] word_byte(input logic [15:0] w, input logic hi);
      return hi ? w[15:8] : w[7:0];
   endfunction

endpackage

// File: rtl/spi_dma_wait.sv
// rtl/spi_dma_wait.sv - loadable down-counter; tc marks the last enabled clock
module spi_dma_wait #(
   parameter int W = 5
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         en,
   output logic         tc
);

   logic [W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt <= '0;
      else if (load)
         cnt <= load_val;
      else if (en && cnt != '0)
         cnt <= cnt - 1'b1;
   end

   assign tc = en && (cnt == '0);

endmodule

// File: rtl/spi_dma_ctrl.sv
// rtl/spi_dma_ctrl.sv - byte-wise DMA between a 16-bit word memory and an SPI engine
module spi_dma_ctrl
   import spi_pkg::*;
#(
   parameter int XFER_WAIT = XFER_WAIT_DEF,
   parameter int AW        = 21
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          go,
   input  logic          abort,
   input  logic          dir,
   input  logic [9:0]    len,
   input  logic [AW-1:0] addr,
   output logic          mem_req,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [15:0]   mem_wdata,
   input  logic [15:0]   mem_rdata,
   input  logic          mem_ack,
   output logic          dma_req,
   output logic [7:0]    dma_din,
   input  logic          spi_start,
   input  logic [7:0]    spi_dout,
   output logic          busy,
   output logic          done
);

   localparam int WW = $clog2(XFER_WAIT + 1);

   state_t      state, state_nx;
   logic        dir_r;
   logic [9:0]  len_r;
   logic [10:0] byte_cnt;
   logic [15:0] word_r;
   logic        wait_load, wait_tc, odd_byte, last_byte, all_done;

   assign odd_byte  = byte_cnt[0];
   assign last_byte = (byte_cnt[9:0] == len_r);
   assign all_done  = (byte_cnt == ({1'b0, len_r} + 11'd1));
   assign wait_load = (state == ST_SEND) && spi_start && !abort;

   // Loaded with XFER_WAIT-1 on the accepting clock so WAIT lasts exactly XFER_WAIT clocks.
   spi_dma_wait #(.W(WW)) u_wait (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (wait_load),
      .load_val (WW'(XFER_WAIT - 1)),
      .en       (state == ST_WAIT),
      .tc       (wait_tc)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= ST_IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      mem_req  = 1'b0;
      mem_we   = 1'b0;
      dma_req  = 1'b0;
      dma_din  = 8'h00;
      case (state)
         ST_IDLE:
            if (go) state_nx = dir ? ST_FETCH : ST_SEND;
         ST_FETCH: begin
            mem_req = 1'b1;
            if (mem_ack) state_nx = ST_SEND;
         end
         ST_SEND: begin
            dma_req = 1'b1;
            dma_din = dir_r ? word_byte(word_r, odd_byte) : 8'hFF;
            if (spi_start) state_nx = ST_WAIT;
         end
         ST_WAIT:
            if (wait_tc) begin
               if (dir_r)
                  state_nx = last_byte ? ST_FIN : (odd_byte ? ST_FETCH : ST_SEND);
               else
                  state_nx = (odd_byte || last_byte) ? ST_STORE : ST_SEND;
            end
         ST_STORE: begin
            mem_req = 1'b1;
            mem_we  = 1'b1;
            if (mem_ack) state_nx = all_done ? ST_FIN : ST_SEND;
         end
         ST_FIN:
            state_nx = ST_IDLE;
         default:
            state_nx = ST_IDLE;
      endcase
      if (abort) state_nx = ST_IDLE;
   end

   assign busy      = (state != ST_IDLE);
   assign done      = (state == ST_FIN);
   assign mem_wdata = word_r;

   // An even-index rx byte pre-fills the high half with FF; an odd byte, if any, overwrites it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dir_r    <= 1'b0;
         len_r    <= '0;
         mem_addr <= '0;
         byte_cnt <= '0;
         word_r   <= '0;
      end else if (!abort) begin
         if (state == ST_IDLE && go) begin
            dir_r    <= dir;
            len_r    <= len;
            mem_addr <= addr;
            byte_cnt <= '0;
         end
         if (mem_req && mem_ack) begin
            mem_addr <= mem_addr + 1'b1;
            if (!mem_we) word_r <= mem_rdata;
         end
         if (state == ST_WAIT && wait_tc) begin
            byte_cnt <= byte_cnt + 11'd1;
            if (odd_byte)
               word_r[15:8] <= spi_dout;
            else
               word_r <= {(dir_r ? word_r[15:8] : 8'hFF), spi_dout};
         end
      end
   end

endmodule

// File: tb/tb_spi_dma_ctrl.sv
// tb/tb_spi_dma_ctrl.sv - self-checking bench for spi_dma_ctrl
module tb_spi_dma_ctrl;

   localparam int XW = 17;
   localparam int AW = 21;

   typedef struct {
      logic          dir;
      logic [9:0]    len;
      logic [AW-1:0] addr;
      int            sdly;
      bit            fixed_rx;
      logic [AW-1:0] exp_end;
      int            exp_ops;
   } vec_t;

   logic          clk = 1'b0;
   logic          rst_n, go, abort, dir;
   logic [9:0]    len;
   logic [AW-1:0] addr;
   logic          mem_req, mem_we, mem_ack, dma_req, spi_start, busy, done;
   logic [AW-1:0] mem_addr;
   logic [15:0]   mem_wdata, mem_rdata;
   logic [7:0]    dma_din, spi_dout;

   int n_cmp, n_fail;
   int done_cnt = 0;
   int dreq_cnt = 0;
   int spi_dly_force = -1;
   bit abort_on_ack = 0;

   logic [15:0]      mem [int];
   logic [7:0]       rx_q[$];
   logic [7:0]       dma_log[$];
   logic [AW-1:0]    rd_log[$];
   logic [AW+15:0]   wr_log[$];

   spi_dma_ctrl dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .go        (go),
      .abort     (abort),
      .dir       (dir),
      .len       (len),
      .addr      (addr),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ack   (mem_ack),
      .dma_req   (dma_req),
      .dma_din   (dma_din),
      .spi_start (spi_start),
      .spi_dout  (spi_dout),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (done) done_cnt <= done_cnt + 1;
      if (dma_req) dreq_cnt <= dreq_cnt + 1;
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Memory: random ack latency, occasional stray acks, optional abort on a write ack.
   initial begin
      int md;
      md = -1; mem_ack = 1'b0; mem_rdata = '0; abort = 1'b0;
      forever begin
         @(posedge clk); #1;
         mem_ack = 1'b0; abort = 1'b0; mem_rdata = 16'($urandom);
         if (!rst_n) md = -1;
         else if (mem_req) begin
            if (md < 0) md = $urandom_range(0, 3);
            if (md == 0) begin
               mem_ack = 1'b1; md = -1;
               if (abort_on_ack && mem_we) abort = 1'b1;
               else if (mem_we) begin
                  wr_log.push_back({mem_addr, mem_wdata});
                  mem[int'(mem_addr)] = mem_wdata;
               end else begin
                  rd_log.push_back(mem_addr);
                  mem_rdata = mem.exists(int'(mem_addr)) ? mem[int'(mem_addr)] : 16'h0000;
               end
            end else md--;
         end else if ($urandom_range(0, 7) == 0) mem_ack = 1'b1;
      end
   end

   // SPI: accepts after a delay; received byte is valid only in the capture cycle.
   initial begin
      int sd, pend;
      logic [7:0] cur;
      sd = -1; pend = 0; cur = '0; spi_start = 1'b0; spi_dout = '0;
      forever begin
         @(posedge clk); #1;
         spi_start = 1'b0; spi_dout = 8'($urandom);
         if (!rst_n) begin
            sd = -1; pend = 0;
         end else begin
            if (pend > 0) begin
               pend--;
               if (pend == 0) spi_dout = cur;
            end
            if (dma_req) begin
               if (sd < 0) sd = (spi_dly_force >= 0) ? spi_dly_force : $urandom_range(0, 3);
               if (sd == 0) begin
                  spi_start = 1'b1;
                  dma_log.push_back(dma_din);
                  cur = (rx_q.size() > 0) ? rx_q.pop_front() : 8'h5A;
                  pend = XW; sd = -1;
               end else sd--;
            end
         end
      end
   end

   task automatic pulse_go(input logic d, input logic [9:0] l, input logic [AW-1:0] a);
      @(posedge clk); #1;
      go = 1'b1; dir = d; len = l; addr = a;
      @(posedge clk); #1;
      go = 1'b0; dir = 1'($urandom); len = 10'($urandom); addr = AW'($urandom);
   endtask

   task automatic run_xfer(input logic d, input logic [9:0] l, input logic [AW-1:0] a,
                           input int sdly, input bit fixed_rx, input bit extra_go, output int ops);
      logic [7:0]     rxb[$];
      logic [7:0]     exp_dma[$];
      logic [AW-1:0]  exp_rd[$];
      logic [AW+15:0] exp_wr[$];
      logic [AW-1:0]  wa;
      logic [15:0]    w;
      int nb, nw, d0, r0;
      bit ok;
      nb = int'(l) + 1;
      nw = (nb + 1) / 2;
      for (int k = 0; k < nw; k++) begin
         wa = a + AW'(k);
         if (d) begin
            if (!mem.exists(int'(wa))) mem[int'(wa)] = 16'($urandom);
            exp_rd.push_back(wa);
         end
      end
      for (int i = 0; i < nb; i++) begin
         rxb.push_back(fixed_rx ? 8'(8'h11 * (i + 1)) : 8'($urandom));
         wa = a + AW'(i / 2);
         w  = mem.exists(int'(wa)) ? mem[int'(wa)] : 16'h0000;
         exp_dma.push_back(d ? ((i % 2) ? w[15:8] : w[7:0]) : 8'hFF);
      end
      if (!d) begin
         for (int k = 0; k < nw; k++) begin
            wa = a + AW'(k);
            w  = {((2 * k + 1 < nb) ? rxb[2 * k + 1] : 8'hFF), rxb[2 * k]};
            exp_wr.push_back({wa, w});
         end
      end
      rx_q = rxb;
      dma_log.delete(); rd_log.delete(); wr_log.delete();
      spi_dly_force = sdly;
      d0 = done_cnt; r0 = dreq_cnt;
      pulse_go(d, l, a);
      ok = 1'b0;
      for (int c = 0; c < 40000; c++) begin
         @(negedge clk);
         if (extra_go && c == 30) begin
            go = 1'b1; dir = ~d; len = 10'd7; addr = '0;
         end else go = 1'b0;
         if (!busy) begin
            ok = 1'b1;
            break;
         end
      end
      go = 1'b0;
      chk("xfer_complete", ok, 1);
      chk("dma_count", dma_log.size(), exp_dma.size());
      for (int i = 0; i < exp_dma.size() && i < dma_log.size(); i++)
         chk($sformatf("dma_din[%0d]", i), dma_log[i], exp_dma[i]);
      chk("read_count", rd_log.size(), exp_rd.size());
      for (int i = 0; i < exp_rd.size() && i < rd_log.size(); i++)
         chk($sformatf("read_addr[%0d]", i), rd_log[i], exp_rd[i]);
      chk("write_count", wr_log.size(), exp_wr.size());
      for (int i = 0; i < exp_wr.size() && i < wr_log.size(); i++)
         chk($sformatf("write[%0d]", i), wr_log[i], exp_wr[i]);
      chk("done_pulses", done_cnt - d0, 1);
      wa = a + AW'(nw);
      chk("end_addr", mem_addr, wa);
      if (sdly >= 0) chk("dma_req_cycles", dreq_cnt - r0, nb * (sdly + 1));
      spi_dly_force = -1;
      ops = rd_log.size() + wr_log.size();
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_busy"},    busy, 0);
      chk({tag, "_done"},    done, 0);
      chk({tag, "_mem_req"}, mem_req, 0);
      chk({tag, "_mem_we"},  mem_we, 0);
      chk({tag, "_dma_req"}, dma_req, 0);
      chk({tag, "_mem_addr"}, mem_addr, 0);
      chk({tag, "_wdata"},   mem_wdata, 0);
      chk({tag, "_dma_din"}, dma_din, 0);
   endtask

   initial begin
      vec_t tbl[8];
      int ops, d0, busy_seen;
      bit ok;
      logic d;
      logic [9:0] l;
      n_cmp = 0; n_fail = 0;
      rst_n = 1'b0; go = 1'b0; dir = 1'b0; len = '0; addr = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_reset_outputs("reset");
      @(posedge clk); #1;
      rst_n = 1'b1;

      mem[32'h100] = 16'hBBAA;
      mem[32'h101] = 16'hDDCC;
      tbl[0] = '{1'b1, 10'd3, 21'h000100, -1, 1'b0, 21'h000102, 2};
      tbl[1] = '{1'b0, 10'd2, 21'h000200, -1, 1'b1, 21'h000202, 2};
      tbl[2] = '{1'b0, 10'd0, 21'h000300,  4, 1'b0, 21'h000301, 1};
      tbl[3] = '{1'b1, 10'd0, 21'h000010, -1, 1'b0, 21'h000011, 1};
      tbl[4] = '{1'b1, 10'd4, 21'h000020,  2, 1'b0, 21'h000023, 3};
      tbl[5] = '{1'b1, 10'd3, 21'h1FFFFF, -1, 1'b0, 21'h000001, 2};
      tbl[6] = '{1'b0, 10'd1, 21'h1FFFFF, -1, 1'b0, 21'h000000, 1};
      tbl[7] = '{1'b0, 10'd5, 21'h000040,  0, 1'b0, 21'h000043, 3};

      for (int i = 0; i < 8; i++) begin
         run_xfer(tbl[i].dir, tbl[i].len, tbl[i].addr, tbl[i].sdly, tbl[i].fixed_rx, 1'b0, ops);
         chk($sformatf("tbl%0d_ops", i), ops, tbl[i].exp_ops);
         chk($sformatf("tbl%0d_end", i), mem_addr, tbl[i].exp_end);
         if (i == 0 && dma_log.size() == 4) begin
            chk("tx_byte0", dma_log[0], 8'hAA);
            chk("tx_byte1", dma_log[1], 8'hBB);
            chk("tx_byte2", dma_log[2], 8'hCC);
            chk("tx_byte3", dma_log[3], 8'hDD);
         end
         if (i == 1) begin
            chk("rx_word0", mem[32'h200], 16'h2211);
            chk("rx_word1", mem[32'h201], 16'hFF33);
         end
         if (i == 5 && rd_log.size() == 2) chk("wrap_read", rd_log[1], 0);
      end

      for (int r = 0; r < 10; r++) begin
         d = 1'($urandom);
         l = (r == 9) ? 10'd40 : 10'($urandom_range(0, 9));
         if (r == 3) l = 10'd6;
         run_xfer(d, l, AW'($urandom), -1, 1'b0, (r == 3), ops);
      end

      // Abort coinciding with the write ack in STORE.
      rx_q.delete(); rx_q.push_back(8'h12); rx_q.push_back(8'h34);
      wr_log.delete();
      abort_on_ack = 1'b1;
      d0 = done_cnt;
      pulse_go(1'b0, 10'd1, 21'h000400);
      ok = 1'b0;
      for (int c = 0; c < 2000; c++) begin
         @(negedge clk);
         if (abort) begin
            ok = 1'b1;
            break;
         end
      end
      chk("abort_seen", ok, 1);
      chk("abort_in_store", mem_req && mem_we && mem_ack, 1);
      @(negedge clk);
      abort_on_ack = 1'b0;
      chk("abort_busy", busy, 0);
      chk("abort_mem_req", mem_req, 0);
      chk("abort_dma_req", dma_req, 0);
      chk("abort_addr_hold", mem_addr, 21'h000400);
      repeat (4) @(negedge clk);
      chk("abort_no_done", done_cnt - d0, 0);
      chk("abort_no_write", wr_log.size(), 0);

      // Reset while in WAIT.
      rx_q.delete();
      pulse_go(1'b0, 10'd3, 21'h000500);
      ok = 1'b0;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         if (dma_req) begin
            ok = 1'b1;
            break;
         end
      end
      for (int c = 0; c < 200 && ok; c++) begin
         @(negedge clk);
         if (!dma_req) break;
      end
      chk("reached_wait", ok, 1);
      repeat (3) @(negedge clk);
      chk("wait_busy", busy, 1);
      rst_n = 1'b0;
      #1;
      chk_reset_outputs("midrst");
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      busy_seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (busy || mem_req || dma_req) busy_seen++;
      end
      chk("no_resume", busy_seen, 0);
      rx_q.delete();

      run_xfer(1'b1, 10'd1, 21'h000600, -1, 1'b0, 1'b0, ops);
      chk("post_reset_ops", ops, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
